// File: rtl/bsg_tag_packet_tx.sv
// Serializing bsg_tag packet transmitter: one packet per valid/ready handshake, LSB-first on tag_data_o.
// Optional reset preamble for the remote tag master is enabled by defining BSG_TAG_TX_PREAMBLE_EN.
module bsg_tag_packet_tx #(
    parameter int unsigned els_p          = 32,
    parameter int unsigned lg_width_p     = 4,
    parameter int unsigned gap_p          = 2,
    parameter int unsigned reset_ones_p   = 64,
    localparam int unsigned id_width      = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int unsigned payload_width = (1 << lg_width_p) - 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    output logic                     ready_o,
    input  logic [id_width-1:0]      node_id_i,
    input  logic                     data_not_reset_i,
    input  logic [lg_width_p-1:0]    len_i,
    input  logic [payload_width-1:0] payload_i,
    output logic                     tag_data_o,
    output logic                     tag_en_o,
    output logic                     busy_o
);

    localparam int unsigned hdr_width   = 2 + id_width + lg_width_p;
    localparam int unsigned frame_width = hdr_width + payload_width;
    localparam int unsigned cnt_max_a   = (frame_width > gap_p) ? frame_width : gap_p;
    localparam int unsigned cnt_max     = (cnt_max_a > reset_ones_p) ? cnt_max_a : reset_ones_p;
    localparam int unsigned cnt_width   = $clog2(cnt_max + 1);

`ifdef BSG_TAG_TX_PREAMBLE_EN
    typedef enum logic [1:0] {IDLE, SEND, GAP, PREAMBLE} state_e;
    localparam state_e                 reset_state = PREAMBLE;
    localparam logic [cnt_width-1:0]   reset_cnt   = cnt_width'(reset_ones_p);
`else
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;
    localparam state_e                 reset_state = IDLE;
    localparam logic [cnt_width-1:0]   reset_cnt   = '0;
`endif

    state_e                   state_r, state_n;
    logic [frame_width-1:0]   shift_r, shift_n;
    logic [cnt_width-1:0]     cnt_r, cnt_n;
    logic                     data_n, en_n;

    logic [lg_width_p-1:0]    len_clamped;
    logic [payload_width-1:0] payload_masked;
    logic [frame_width-1:0]   frame;
    logic [cnt_width-1:0]     frame_len;

    // Frame assembly from the handshake inputs; payload bits at and above len are zeroed
    always_comb begin
        len_clamped = (len_i > lg_width_p'(payload_width)) ? lg_width_p'(payload_width) : len_i;
        for (int i = 0; i < payload_width; i++) begin
            payload_masked[i] = payload_i[i] & (lg_width_p'(i) < len_clamped);
        end
        frame     = {payload_masked, len_clamped, data_not_reset_i, node_id_i, 1'b1};
        frame_len = cnt_width'(hdr_width) + cnt_width'(len_clamped);
    end

    // Next state and next-cycle wire values; cnt in SEND counts bits left including the one on the wire
    always_comb begin
        state_n = state_r;
        shift_n = shift_r;
        cnt_n   = cnt_r;
        data_n  = 1'b0;
        en_n    = 1'b0;
        case (state_r)
            IDLE: begin
                if (v_i && ready_o) begin
                    state_n = SEND;
                    data_n  = frame[0];
                    en_n    = 1'b1;
                    shift_n = frame >> 1;
                    cnt_n   = frame_len;
                end
            end
            SEND: begin
                if (cnt_r == cnt_width'(1)) begin
                    state_n = GAP;
                    cnt_n   = cnt_width'(gap_p);
                end else begin
                    data_n  = shift_r[0];
                    en_n    = 1'b1;
                    shift_n = shift_r >> 1;
                    cnt_n   = cnt_r - cnt_width'(1);
                end
            end
            GAP: begin
                if (cnt_r == cnt_width'(1)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_r - cnt_width'(1);
                end
            end
`ifdef BSG_TAG_TX_PREAMBLE_EN
            PREAMBLE: begin
                if (cnt_r == '0) begin
                    state_n = GAP;
                    cnt_n   = cnt_width'(gap_p);
                end else begin
                    data_n = 1'b1;
                    en_n   = 1'b1;
                    cnt_n  = cnt_r - cnt_width'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any frame in flight
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r    <= reset_state;
            shift_r    <= '0;
            cnt_r      <= reset_cnt;
            ready_o    <= 1'b0;
            tag_data_o <= 1'b0;
            tag_en_o   <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            state_r    <= state_n;
            shift_r    <= shift_n;
            cnt_r      <= cnt_n;
            ready_o    <= (state_n == IDLE);
            tag_data_o <= data_n;
            tag_en_o   <= en_n;
            busy_o     <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_bsg_tag_packet_tx.sv
// Self-checking bench for bsg_tag_packet_tx: vector table plus scoreboard of expected serial bits.
// Define BSG_TAG_TX_PREAMBLE_EN for both files to exercise the preamble build.
module tb_bsg_tag_packet_tx;

    localparam int GAP = 2;
    localparam int PRE = 64;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic        ready_o;
    logic [4:0]  node_id_i;
    logic        data_not_reset_i;
    logic [3:0]  len_i;
    logic [14:0] payload_i;
    logic        tag_data_o;
    logic        tag_en_o;
    logic        busy_o;

    bsg_tag_packet_tx #(.els_p(32), .lg_width_p(4), .gap_p(GAP), .reset_ones_p(PRE)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .v_i              (v_i),
        .ready_o          (ready_o),
        .node_id_i        (node_id_i),
        .data_not_reset_i (data_not_reset_i),
        .len_i            (len_i),
        .payload_i        (payload_i),
        .tag_data_o       (tag_data_o),
        .tag_en_o         (tag_en_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  id;
        logic        dnr;
        logic [3:0]  len;
        logic [14:0] pay;
        logic [25:0] bits;
        int          n;
    } vec_t;

    vec_t vecs [8];
    bit   exp_q [$];
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 0;
    bit   in_b2b = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] id, input logic dnr, input logic [3:0] len,
                                input logic [14:0] pay);
        vec_t v;
        int   k;
        v.id = id; v.dnr = dnr; v.len = len; v.pay = pay;
        v.bits = '0;
        k = 0;
        v.bits[k] = 1'b1; k++;
        for (int i = 0; i < 5; i++) begin v.bits[k] = id[i]; k++; end
        v.bits[k] = dnr; k++;
        for (int i = 0; i < 4; i++) begin v.bits[k] = len[i]; k++; end
        for (int i = 0; i < int'(len); i++) begin v.bits[k] = pay[i]; k++; end
        v.n = k;
        return v;
    endfunction

    // Monitor: every enabled bit is popped from the scoreboard; idle cycles must carry data 0
    int low_run = 0;
    bit prev_en = 0;
    bit b2b_seen = 0;
    always @(negedge clk_i) begin
        if (!in_b2b) b2b_seen = 0;
        if (mon_en) begin
            if (tag_en_o) begin
                // Separation = gap_p GAP cycles plus the IDLE cycle in which the handshake is taken
                if (!prev_en && b2b_seen) chk("b2b_idle_cycles", low_run, GAP + 1);
                if (exp_q.size() == 0) chk("extra_bit_queue", exp_q.size(), 1);
                else chk("serial_bit", tag_data_o, exp_q.pop_front());
                low_run  = 0;
                b2b_seen = in_b2b;
            end else begin
                chk("idle_data_zero", tag_data_o, 0);
                low_run++;
            end
            chk("busy_vs_ready", busy_o, !ready_o);
        end
        prev_en = tag_en_o;
    end

    task automatic scramble();
        node_id_i        = 5'($urandom);
        data_not_reset_i = 1'($urandom);
        len_i            = 4'($urandom);
        payload_i        = 15'($urandom);
    endtask

    // Drive one packet; returns at the first sample after the handshake edge
    task automatic send(input vec_t v, input bit hold);
        int w = 0;
        node_id_i = v.id; data_not_reset_i = v.dnr; len_i = v.len; payload_i = v.pay;
        v_i = 1'b1;
        while (!ready_o && w < 100) begin @(negedge clk_i); w++; end
        if (!ready_o) begin
            chk("ready_timeout", ready_o, 1);
            v_i = 1'b0;
            return;
        end
        for (int i = 0; i < v.n; i++) exp_q.push_back(v.bits[i]);
        @(negedge clk_i);
        if (!hold) v_i = 1'b0;
    endtask

    // Wait for ready while changing the unused inputs every cycle; returns the sample index
    task automatic wait_ready(output int cyc);
        cyc = 1;
        while (!ready_o && cyc < 100) begin
            scramble();
            @(negedge clk_i);
            cyc++;
        end
        if (!ready_o) chk("wait_ready_timeout", ready_o, 1);
    endtask

    task automatic post_reset_check();
`ifdef BSG_TAG_TX_PREAMBLE_EN
        int bad = 0;
        for (int i = 0; i < PRE; i++) begin
            @(negedge clk_i);
            if (!(tag_en_o === 1'b1 && tag_data_o === 1'b1 && ready_o === 1'b0 && busy_o === 1'b1))
                bad++;
        end
        chk("preamble_ones_bad_cycles", bad, 0);
        for (int i = 0; i < GAP; i++) begin
            @(negedge clk_i);
            chk("preamble_gap_en", tag_en_o, 0);
            chk("preamble_gap_ready", ready_o, 0);
        end
        @(negedge clk_i);
        chk("ready_after_preamble", ready_o, 1);
`else
        @(negedge clk_i);
        chk("ready_after_reset", ready_o, 1);
        chk("en_after_reset", tag_en_o, 0);
        chk("busy_after_reset", busy_o, 0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        vecs[0] = '{5'd21, 1'b1, 4'd3,  15'b101,   26'b10100111101011, 14};
        vecs[1] = '{5'd0,  1'b0, 4'd0,  15'h7FFF,  26'd1, 11};
        vecs[2] = '{5'd5,  1'b1, 4'd15, 15'h7FFF,  26'b11111111111111111111001011, 26};
        vecs[3] = '{5'd31, 1'b0, 4'd7,  15'h7F26,  26'b010011001110111111, 18};
        for (int i = 4; i < 8; i++)
            vecs[i] = mk(5'($urandom), 1'($urandom), 4'($urandom_range(1, 14)), 15'($urandom));

        reset_n_i = 1'b0;
        v_i = 1'b0;
        scramble();
        repeat (3) @(negedge clk_i);
        chk("reset_ready", ready_o, 0);
        chk("reset_data", tag_data_o, 0);
        chk("reset_en", tag_en_o, 0);
        chk("reset_busy", busy_o, 0);
        reset_n_i = 1'b1;
        post_reset_check();
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i], 1'b0);
            if (i == 0) chk("start_bit_latency_en", tag_en_o, 1);
            wait_ready(cyc);
            if (i == 0) chk("ready_latency", cyc, 17);
        end

        in_b2b = 1'b1;
        send(vecs[0], 1'b1);
        send(vecs[2], 1'b1);
        send(vecs[3], 1'b0);
        wait_ready(cyc);
        in_b2b = 1'b0;

        send(vecs[2], 1'b0);
        repeat (5) @(negedge clk_i);
        #1;
        mon_en = 1'b0;
        reset_n_i = 1'b0;
        exp_q.delete();
        @(negedge clk_i);
        chk("abort_en", tag_en_o, 0);
        chk("abort_data", tag_data_o, 0);
        chk("abort_ready", ready_o, 0);
        chk("abort_busy", busy_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        post_reset_check();
        mon_en = 1'b1;

        send(vecs[3], 1'b0);
        wait_ready(cyc);

        cyc = 0;
        while ((exp_q.size() != 0 || tag_en_o) && cyc < 100) begin @(negedge clk_i); cyc++; end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
